// File: rtl/frame_pkg.sv
// frame_pkg: shared definitions for the frame responder and its CRC helper.
// Holds the state encoding, the CRC-8 constants, the display_status codes,
// the default NAK byte and the byte-wide CRC update function.
package frame_pkg;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_RX_PAYLOAD = 4'd1;
  localparam logic [3:0] ST_RX_CRC     = 4'd2;
  localparam logic [3:0] ST_CHECK      = 4'd3;
  localparam logic [3:0] ST_TX_START   = 4'd4;
  localparam logic [3:0] ST_TX_WAIT_HI = 4'd5;
  localparam logic [3:0] ST_TX_WAIT_LO = 4'd6;

  typedef enum logic [3:0] {
    IDLE       = ST_IDLE,
    RX_PAYLOAD = ST_RX_PAYLOAD,
    RX_CRC     = ST_RX_CRC,
    CHECK      = ST_CHECK,
    TX_START   = ST_TX_START,
    TX_WAIT_HI = ST_TX_WAIT_HI,
    TX_WAIT_LO = ST_TX_WAIT_LO
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam logic [1:0] DISP_IDLE = 2'b11;
  localparam logic [1:0] DISP_RX   = 2'b10;
  localparam logic [1:0] DISP_OK   = 2'b01;
  localparam logic [1:0] DISP_ERR  = 2'b00;

  localparam logic [7:0] ACK_NAK_DEFAULT = 8'h15;

  // One byte folded into a CRC-8 register, MSB first, no reflection.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data);
    logic [7:0] r;
    r = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ CRC8_POLY) : (r << 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc8_byte.sv
// crc8_byte: combinational byte-parallel CRC-8 step (poly 0x07).
// Shared between the frame sender and the frame responder.
module crc8_byte
  import frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  assign crc_out = crc8_update(crc_in, data);

endmodule

// File: rtl/frame_responder.sv
// frame_responder: receives MSG_LEN payload bytes plus a CRC-8 byte, checks
// the CRC, then echoes payload + fresh CRC (good frame) or one NAK byte (bad).
// Optional inter-byte timeout is built when FRAME_RESP_TIMEOUT_EN is defined;
// without it a partial frame waits indefinitely.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for the first payload byte
// RX_PAYLOAD | collecting payload bytes 1..MSG_LEN-1
// RX_CRC     | waiting for the CRC byte
// CHECK      | one cycle: judge CRC, pulse frame_ok/frame_err, pick response
// TX_START   | issue tx_start once uart_tx is free
// TX_WAIT_HI | wait for uart_tx to report busy
// TX_WAIT_LO | wait for uart_tx to finish, then next byte or back to IDLE
module frame_responder
  import frame_pkg::*;
#(
  parameter int         MSG_LEN        = 3,
  parameter logic [7:0] ACK_NAK_BYTE   = ACK_NAK_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic [1:0] display_status
);

  localparam logic [3:0] LAST_PAY = 4'(MSG_LEN - 1);
  localparam logic [3:0] LAST_ECHO = 4'(MSG_LEN);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] ridx;
  logic [7:0] crc;
  logic [7:0] payload_crc;
  logic       nak;
  logic [7:0] pay_buf [16];
  logic [7:0] crc_seed;
  logic [7:0] crc_next;
  logic [7:0] resp_byte;
  logic       tmo_hit;

  // A new frame always starts from the CRC init value, whatever is left over.
  assign crc_seed = (state == IDLE) ? CRC8_INIT : crc;

  crc8_byte u_crc (
    .crc_in  (crc_seed),
    .data    (rx_data),
    .crc_out (crc_next)
  );

  // Response byte at ridx: NAK alone, or payload bytes then the payload CRC.
  always_comb begin
    resp_byte = payload_crc;
    if (nak) begin
      resp_byte = ACK_NAK_BYTE;
    end else if (ridx < LAST_ECHO) begin
      resp_byte = pay_buf[ridx];
    end
  end

`ifdef FRAME_RESP_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt;
  logic        in_rx;

  assign in_rx   = (state == RX_PAYLOAD) || (state == RX_CRC);
  assign tmo_hit = in_rx && !rx_done && (tmo_cnt == TMO_LAST);

  // Inter-byte silence counter, only running while a frame is half received.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (rx_done || !in_rx) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Payload capture; the response is replayed straight out of this buffer.
  always_ff @(posedge clk) begin
    if (!reset && rx_done) begin
      if (state == IDLE) begin
        pay_buf[0] <= rx_data;
      end else if (state == RX_PAYLOAD) begin
        pay_buf[idx] <= rx_data;
      end
    end
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tx_start       <= 1'b0;
      tx_data        <= 8'h00;
      frame_ok       <= 1'b0;
      frame_err      <= 1'b0;
      err_count      <= 8'h00;
      display_status <= DISP_IDLE;
      idx            <= 4'd0;
      ridx           <= 4'd0;
      crc            <= CRC8_INIT;
      payload_crc    <= CRC8_INIT;
      nak            <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done) begin
            crc            <= crc_next;
            payload_crc    <= crc_next;
            idx            <= 4'd1;
            display_status <= DISP_RX;
            state          <= (MSG_LEN == 1) ? RX_CRC : RX_PAYLOAD;
          end
        end
        RX_PAYLOAD: begin
          if (rx_done) begin
            crc         <= crc_next;
            payload_crc <= crc_next;
            if (idx == LAST_PAY) begin
              state <= RX_CRC;
            end else begin
              idx <= idx + 4'd1;
            end
          end else if (tmo_hit) begin
            state          <= IDLE;
            frame_err      <= 1'b1;
            display_status <= DISP_ERR;
            crc            <= CRC8_INIT;
            idx            <= 4'd0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        RX_CRC: begin
          if (rx_done) begin
            crc   <= crc_next;
            state <= CHECK;
          end else if (tmo_hit) begin
            state          <= IDLE;
            frame_err      <= 1'b1;
            display_status <= DISP_ERR;
            crc            <= CRC8_INIT;
            idx            <= 4'd0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        CHECK: begin
          ridx <= 4'd0;
          if (crc == 8'h00) begin
            frame_ok       <= 1'b1;
            display_status <= DISP_OK;
            nak            <= 1'b0;
          end else begin
            frame_err      <= 1'b1;
            display_status <= DISP_ERR;
            nak            <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
          state <= TX_START;
        end
        TX_START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= resp_byte;
            state    <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (tx_busy) state <= TX_WAIT_LO;
        end
        TX_WAIT_LO: begin
          if (!tx_busy) begin
            if (ridx == (nak ? 4'd0 : LAST_ECHO)) begin
              state <= IDLE;
              ridx  <= 4'd0;
              idx   <= 4'd0;
              crc   <= CRC8_INIT;
            end else begin
              ridx  <= ridx + 4'd1;
              state <= TX_START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_responder.sv
// tb_frame_responder: randomized frames against a queue-based reference model
// of the responder, with a simple uart_tx busy model capturing every tx byte.
module tb_frame_responder;

  localparam int         MSG_LEN = 3;
  localparam int         TMO     = 100;
  localparam logic [7:0] NAK     = 8'h15;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_count;
  logic [1:0] display_status;

  int checks   = 0;
  int failures = 0;

  logic [7:0] pl[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         busy_len = 20;
  int         exp_errs = 0;
  logic [1:0] exp_disp = 2'b11;

  frame_responder #(
    .MSG_LEN        (MSG_LEN),
    .ACK_NAK_BYTE   (NAK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_done        (rx_done),
    .rx_data        (rx_data),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err),
    .err_count      (err_count),
    .display_status (display_status)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-8 (poly 0x07) over a whole message.
  function automatic logic [7:0] crc8(input logic [7:0] q[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (q[i]) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = c[7] ^ q[i][b];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // uart_tx model: busy for busy_len cycles after each tx_start.
  initial begin : uart_model
    logic [7:0] held;
    logic       ok;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        held = tx_data;
        got_q.push_back(held);
        tx_busy = 1'b1;
        ok = 1'b1;
        repeat (busy_len) begin
          @(negedge clk);
          if (tx_start !== 1'b0 || tx_data !== held) ok = 1'b0;
        end
        tx_busy = 1'b0;
        chk("tx_hold", 32'(ok), 32'd1);
      end
    end
  end

  // Called at a negedge; returns at the following negedge with rx_done low.
  task automatic put_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Sends pl plus (crc ^ crc_xor); stray >= 0 injects a byte during the reply.
  task automatic send_frame(input logic [7:0] crc_xor, input int stray);
    logic [7:0] c;
    logic       good;
    int         cyc;
    c    = crc8(pl) ^ crc_xor;
    good = (crc_xor == 8'h00);
    exp_q.delete();
    if (good) begin
      foreach (pl[i]) exp_q.push_back(pl[i]);
      exp_q.push_back(crc8(pl));
    end else begin
      exp_q.push_back(NAK);
    end
    got_q.delete();
    foreach (pl[i]) begin
      put_byte(pl[i]);
      if (i == 0) chk("disp_rx", 32'(display_status), 32'(2'b10));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    put_byte(c);
    @(negedge clk);
    chk("frame_ok", 32'(frame_ok), 32'(good));
    chk("frame_err", 32'(frame_err), 32'(!good));
    if (!good && exp_errs < 255) exp_errs++;
    exp_disp = good ? 2'b01 : 2'b00;
    chk("disp_result", 32'(display_status), 32'(exp_disp));
    chk("err_count", 32'(err_count), 32'(exp_errs));
    @(negedge clk);
    chk("tx_start_lat", 32'(tx_start), 32'd1);
    chk("pulse_width", 32'(frame_ok | frame_err), 32'd0);
    if (stray >= 0) begin
      repeat (stray) @(negedge clk);
      put_byte(8'h4F);
    end
    cyc = 0;
    while ((got_q.size() < exp_q.size() || tx_busy) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("resp_timeout", 32'(cyc < 5000), 32'd1);
    repeat (4) @(negedge clk);
    chk("resp_len", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) chk("resp_byte", 32'(got_q[i]), 32'(exp_q[i]));
    end
    chk("disp_hold", 32'(display_status), 32'(exp_disp));
    chk("err_count_end", 32'(err_count), 32'(exp_errs));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_disp", 32'(display_status), 32'(2'b11));
    reset = 1'b0;
    @(negedge clk);

    // Known-good frame, then the same frame with a bad CRC byte.
    pl = '{8'h4F, 8'h4C, 8'h41};
    chk("ref_crc", 32'(crc8(pl)), 32'h0A6);
    send_frame(8'h00, -1);
    send_frame(8'h01, -1);

    // Stray byte while a reply is going out, then a clean good frame.
    send_frame(8'h00, 5);
    send_frame(8'h00, -1);

    // Randomized frames with random busy lengths, corruptions and strays.
    for (int k = 0; k < 12; k++) begin
      logic [7:0] x;
      pl.delete();
      for (int j = 0; j < MSG_LEN; j++) pl.push_back(8'($urandom));
      busy_len = $urandom_range(1, 12);
      x = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(x, (x == 8'h00 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1);
    end

    // Reset arriving together with the second payload byte.
    busy_len = 20;
    put_byte(8'h4F);
    rx_data = 8'h4C;
    rx_done = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    rx_done = 1'b0;
    exp_errs = 0;
    exp_disp = 2'b11;
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_disp", 32'(display_status), 32'(2'b11));
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    pl = '{8'h4F, 8'h4C, 8'h41};
    send_frame(8'h00, -1);

`ifdef FRAME_RESP_TIMEOUT_EN
    begin : timeout_test
      int cyc;
      got_q.delete();
      put_byte(8'h4F);
      cyc = 0;
      while (frame_err !== 1'b1 && cyc < TMO + 50) begin
        @(negedge clk);
        cyc++;
      end
      if (exp_errs < 255) exp_errs++;
      chk("tmo_cycle", 32'(cyc), 32'(TMO));
      chk("tmo_disp", 32'(display_status), 32'(2'b00));
      chk("tmo_err_count", 32'(err_count), 32'(exp_errs));
      repeat (10) @(negedge clk);
      chk("tmo_no_tx", 32'(got_q.size()), 32'd0);
      send_frame(8'h00, -1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_responder.md
Name: frame_responder

Overview:
- Far-end partner of the frame-sending controller.
- Receives a fixed-length frame from uart_rx: MSG_LEN payload bytes followed by one CRC-8 byte.
- Checks the CRC. Good frame: echoes payload plus a freshly computed CRC through uart_tx. Bad frame: sends a single NAK byte.
- Drives display_status with the same code set as the rest of the design.

Parameters:
- MSG_LEN, 3, payload bytes per frame (2..15).
- ACK_NAK_BYTE, 8'h15, byte sent on a CRC failure.
- TIMEOUT_CYCLES, 50_000_000, inter-byte timeout in clk cycles. Used only with FRAME_RESP_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- rx_done  in  1  one-cycle strobe from uart_rx: a byte is valid.
- rx_data  in  8  received byte, valid when rx_done=1.
- tx_busy  in  1  uart_tx is serialising.
- tx_start  out  1  one-cycle request to uart_tx.
- tx_data  out  8  byte for uart_tx; held stable from tx_start until tx_busy falls.
- frame_ok  out  1  one-cycle pulse when a good frame has been checked.
- frame_err  out  1  one-cycle pulse on CRC failure (or timeout, if enabled).
- err_count  out  8  saturating count of frame_err pulses.
- display_status  out  2  11 idle, 10 receiving, 01 last frame OK, 00 last frame error.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; tx_start=0, tx_data=0, frame_ok=0, frame_err=0, err_count=0, display_status=11.
  - Byte index=0, CRC register=8'h00.
  - Reset takes priority over every other event, including mid-transmission. tx_start is never asserted in the reset cycle.
- CRC algorithm: CRC-8, polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Byte-parallel update computed combinationally; the register is updated in the same cycle as rx_done.
  - Pass criterion: CRC over payload plus received CRC byte equals 8'h00.
- States:
  - IDLE: on rx_done, store the byte in buf[0], crc=f(0x00,byte), idx=1, display_status=10. Go to RX_PAYLOAD, or RX_CRC when MSG_LEN==1 (disallowed by the parameter range, but it must not hang).
  - RX_PAYLOAD: on rx_done, buf[idx]=byte and crc updated. When idx==MSG_LEN-1 go to RX_CRC; otherwise idx++.
  - RX_CRC: on rx_done, crc updated with the CRC byte. Go to CHECK.
  - CHECK (1 cycle):
    - crc==0: frame_ok=1, display_status=01, load the response sequence buf[0..MSG_LEN-1] followed by the recomputed payload CRC (captured before the CRC byte was folded in). Response length MSG_LEN+1.
    - crc!=0: frame_err=1, err_count saturating increment (255 holds), display_status=00, response = {ACK_NAK_BYTE}, length 1.
    - Go to TX_START.
  - TX_START: when tx_busy==0, tx_start=1 for exactly one cycle with tx_data=resp[ridx]. Go to TX_WAIT_HI.
  - TX_WAIT_HI: wait for tx_busy==1. Go to TX_WAIT_LO.
  - TX_WAIT_LO: when tx_busy==0, if ridx==last go to IDLE (ridx=0, crc=0), else ridx++ and go to TX_START.
- rx_done in CHECK or any TX state: the byte is dropped silently. No error, counters unchanged.
- rx_done coincident with reset: ignored.
- display_status keeps its OK/ERR value through TX and IDLE until the next first byte arrives (then 10).
- Latency: last rx_done to the frame_ok/frame_err pulse = 1 cycle (CHECK registered). To the first tx_start = 2 cycles if tx_busy is low.

Optional Feature:
- Macro FRAME_RESP_TIMEOUT_EN.
- Defined: in RX_PAYLOAD and RX_CRC a counter is cleared on every rx_done and incremented otherwise. When it reaches TIMEOUT_CYCLES-1:
  - abort to IDLE;
  - frame_err pulse, err_count++, display_status=00;
  - no transmission; crc and idx cleared.
- Undefined: no counter logic; a partial frame waits indefinitely.

Decomposition:
- Package frame_pkg holds:
  - state encoding localparams (4-bit);
  - CRC8_POLY=8'h07 and CRC8_INIT=8'h00;
  - display codes DISP_IDLE=2'b11, DISP_RX=2'b10, DISP_OK=2'b01, DISP_ERR=2'b00;
  - NAK default.
- Sub-module crc8_byte: purely combinational, crc_in[7:0] and data[7:0] to crc_out[7:0]. It is shared with the sender side.

Test Plan:
- Good frame: rx 4F,4C,41,A6 → frame_ok pulse, display 01, tx sequence 4F,4C,41,A6 with one tx_start per byte, err_count=0.
- Corrupt CRC: rx 4F,4C,41,A7 → frame_err, display 00, single tx byte 15, err_count=1.
- tx_busy held high 20 cycles after each tx_start → no second tx_start until busy falls. tx_data stable throughout.
- rx_done 4F during TX_WAIT_LO → byte ignored. The next full good frame is still answered correctly.
- Reset asserted during the second payload byte → all outputs return to reset values the next cycle. A following good frame is handled normally.
- FRAME_RESP_TIMEOUT_EN with TIMEOUT_CYCLES=100: rx 4F then silence → frame_err at cycle 100, no tx_start, state IDLE.
